// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions for the decode/issue scoreboard.
//   - opcode constants, register-index and datapath widths
//   - x0 index constant and the decode-to-scoreboard issue request payload
//   - reg_onehot(): one-hot register mask that never selects x0
package pipe_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;

  // Instruction presented by decode for issue.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     use_rs1;
    logic     use_rs2;
    logic     wb;
    logic     load;
  } issue_req_t;

  // One-hot mask of a register; x0 maps to an empty mask so it is never tracked.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (idx != X0) mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rd_fifo.sv
// rd_fifo: circular FIFO of load destination register indices, oldest at head.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, din_i     enqueue din_i (ignored when full unless a pop happens too)
//   pop_i             dequeue the head (ignored when empty)
//   head_o            head entry, 0 when empty
//   count_o           number of valid entries
module rd_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  reg_idx_t                   din_i,
  input  logic                       pop_i,
  output reg_idx_t                   head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  reg_idx_t               mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_pop;
  logic                   do_push;

  assign do_pop  = pop_i & (count_q != '0);
  // A full queue may still accept an entry when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Stale entries remain in storage after a pop, so mask the head when empty.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : X0;
  assign count_o = count_q;

endmodule

// File: rtl/load_scoreboard.sv
// load_scoreboard: decode-stage issue scoreboard for outstanding loads.
// Tracks destinations of in-flight loads (in order), stalls decode on RAW/WAW
// hazards against pending loads or on load-queue overflow, and produces
// EX-stage forwarding selects for the previous non-load result.
// Ports:
//   CLK, reset                     clock, asynchronous active-high reset
//   id_valid, id_rd/rs1/rs2,
//   id_use_rs1/rs2, id_wb, id_load decode instruction fields
//   mem_done                       oldest outstanding load returns this cycle
//   stall, issue_fire              issue handshake (combinational)
//   ld_head_rd, lq_count           load queue head destination and occupancy
//   pending                        per-register outstanding-load bits
//   fwd_ex_rs1, fwd_ex_rs2         source matches the EX-stage ALU result
//   sb_err                         sticky: mem_done seen with no load outstanding
module load_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [REG_IDX_W-1:0]         id_rd,
  input  logic [REG_IDX_W-1:0]         id_rs1,
  input  logic [REG_IDX_W-1:0]         id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         id_wb,
  input  logic                         id_load,
  input  logic                         mem_done,
  output logic                         stall,
  output logic                         issue_fire,
  output logic [REG_IDX_W-1:0]         ld_head_rd,
  output logic [$clog2(LQ_DEPTH):0]    lq_count,
  output logic [NUM_REGS-1:0]          pending,
  output logic                         fwd_ex_rs1,
  output logic                         fwd_ex_rs2,
  output logic                         sb_err
);

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  issue_req_t          req;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  reg_idx_t            ex_rd_q, ex_rd_d;
  logic                sb_err_q, sb_err_d;

  logic                pop;
  reg_idx_t            pop_rd;
  logic                push;
  logic                lq_full;
  logic                raw_rs1, raw_rs2, waw, full_haz;

  // Bundle decode fields.
  always_comb begin
    req         = '0;
    req.valid   = id_valid;
    req.rd      = id_rd;
    req.rs1     = id_rs1;
    req.rs2     = id_rs2;
    req.use_rs1 = id_use_rs1;
    req.use_rs2 = id_use_rs2;
    req.wb      = id_wb;
    req.load    = id_load;
  end

  rd_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_rd_fifo (
    .clk_i   (CLK),
    .rst_i   (reset),
    .push_i  (push),
    .din_i   (req.rd),
    .pop_i   (pop),
    .head_o  (ld_head_rd),
    .count_o (lq_count)
  );

  assign pop     = mem_done & (lq_count != '0);
  assign pop_rd  = ld_head_rd;
  assign lq_full = (lq_count == CNT_W'(LQ_DEPTH));

  // A load returning this cycle writes back now, so its register is not a hazard.
  always_comb begin
    raw_rs1  = req.use_rs1 & (req.rs1 != X0) & pending_q[req.rs1]
             & ~(pop & (pop_rd == req.rs1));
    raw_rs2  = req.use_rs2 & (req.rs2 != X0) & pending_q[req.rs2]
             & ~(pop & (pop_rd == req.rs2));
    waw      = req.wb & (req.rd != X0) & pending_q[req.rd]
             & ~(pop & (pop_rd == req.rd));
    full_haz = req.load & lq_full & ~pop;
  end

  assign stall      = req.valid & (raw_rs1 | raw_rs2 | waw | full_haz);
  assign issue_fire = req.valid & ~stall;
  // Loads to x0 are still queued since memory returns data for them.
  assign push       = issue_fire & req.load;

  // Pending bits: clear on return, then set on issue so a same-register push wins.
  always_comb begin
    pending_d = pending_q;
    if (pop)  pending_d = pending_d & ~reg_onehot(pop_rd);
    if (push) pending_d = pending_d | reg_onehot(req.rd);
  end

  // EX tag holds only the destination of an issued non-load writer.
  always_comb begin
    ex_rd_d = X0;
    if (issue_fire & req.wb & ~req.load) ex_rd_d = req.rd;
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (mem_done & (lq_count == '0)) sb_err_d = 1'b1;
  end

  // Scoreboard state registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      ex_rd_q   <= X0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ex_rd_q   <= ex_rd_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign pending    = pending_q;
  assign sb_err     = sb_err_q;
  assign fwd_ex_rs1 = (ex_rd_q != X0) & (req.rs1 == ex_rd_q) & req.use_rs1;
  assign fwd_ex_rs2 = (ex_rd_q != X0) & (req.rs2 == ex_rd_q) & req.use_rs2;

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Per-register scoreboard and load-queue controller that sequences instruction issue from the decode stage of the 64-bit pipeline. It records which architectural registers have an outstanding load, tracks in-order load returns, and raises `stall` for read-after-write or write-after-write hazards and for load-queue overflow. It also drives EX-stage forwarding selects for ALU results. It sits between decode (issue request) and the execute/memory stages (load completion).

## Interface
- `LQ_DEPTH`, default 2: maximum number of outstanding loads; power of two, at least 2.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `id_valid`  in  1  decode presents an instruction this cycle.
- `id_rd`, `id_rs1`, `id_rs2`  in  5 each  destination and source register indices.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the source is actually read (immediate forms clear `id_use_rs2`).
- `id_wb`  in  1  the instruction writes `id_rd`.
- `id_load`  in  1  the instruction is a load.
- `mem_done`  in  1  single-cycle pulse: the oldest outstanding load has returned its data this cycle.
- `stall`  out  1  decode must hold its instruction (combinational).
- `issue_fire`  out  1  equals `id_valid & !stall` (combinational).
- `ld_head_rd`  out  5  destination of the oldest outstanding load; 0 when the queue is empty.
- `lq_count`  out  $clog2(LQ_DEPTH)+1  number of outstanding loads.
- `pending`  out  32  bit i set means a load to register i is outstanding; bit 0 is always 0.
- `fwd_ex_rs1`, `fwd_ex_rs2`  out  1 each  the source equals the rd of the non-load instruction currently in EX.
- `sb_err`  out  1  sticky flag, set by `mem_done` while the queue is empty.

## Operation
- Register x0 is never pending, never causes a hazard, and never forwards.
- `pop` = `mem_done & lq_count != 0`. `pop_rd` = `ld_head_rd`.
- RAW hazard on rsN = `id_use_rsN & rsN != 0 & pending[rsN] & !(pop & pop_rd == rsN)`. Same-cycle completion bypasses, because writeback supplies the value that cycle.
- WAW hazard = `id_wb & id_rd != 0 & pending[id_rd] & !(pop & pop_rd == id_rd)`.
- Queue-full hazard = `id_load & lq_count == LQ_DEPTH & !pop`.
- `stall` = `id_valid` AND (any of the three hazards).
- On `issue_fire & id_load`, push `id_rd` to the tail of the queue. This also applies when `id_rd` = 0, because memory still returns data. Set `pending[id_rd]` if `id_rd != 0`.
- On `pop`, advance the head and clear `pending[pop_rd]`. If a push sets the same bit in the same cycle, the set wins.
- When push and pop occur together, `lq_count` is unchanged.
- Head and tail pointers wrap modulo `LQ_DEPTH`.
- EX tag register `ex_rd_q`:
  - on `issue_fire & id_wb & !id_load` it loads `id_rd`;
  - otherwise it loads 0.
- `fwd_ex_rsN` = `ex_rd_q != 0 & id_rsN == ex_rd_q & id_use_rsN`.
- A `mem_done` with an empty queue is ignored for all state except `sb_err`, which it sets to 1. Only `reset` clears `sb_err`.

## Timing
- Reset values: `pending` = 0, `lq_count` = 0, head and tail = 0, `ld_head_rd` = 0, `ex_rd_q` = 0, `sb_err` = 0.
- Consequences of reset: `stall` = 0 while `id_valid` = 0; `fwd_ex_rs1` and `fwd_ex_rs2` = 0.
- An asserted `reset` during outstanding loads discards them immediately. Any later `mem_done` then sets `sb_err`.
- Load issue to pending visible: the next cycle.
- `mem_done` to dependent issue: the same cycle (0 bubbles).
- Load to use with memory latency L cycles: the consumer stalls until the `mem_done` cycle.
- Handshake: decode holds all `id_*` stable while `stall` = 1. The scoreboard does not register `stall`.
- `issue_fire` is the sole qualifier for queue pushes and for updating `ex_rd_q`.

## Structure
- Shared package `pipe_pkg`:
  - opcode constants (`OP_ALU`, `OP_ALU_IMM`, `OP_LOAD`);
  - `REG_IDX_W` = 5 and `XLEN` = 64;
  - the x0 index constant.
- One natural sub-module, `rd_fifo`: a `LQ_DEPTH` x 5-bit circular FIFO with push, pop, head data and count.
- The hazard logic and pending bit vector stay in `load_scoreboard`.

## Test plan
- Load x5, then `add x6,x5,x1` next cycle, `mem_done` 3 cycles later -> `stall` = 1 for 3 cycles; `issue_fire` on the `mem_done` cycle; `pending[5]` back to 0 the following cycle.
- `addi x7,x0,1`, then `add x8,x7,x7` -> no stall; `fwd_ex_rs1` = `fwd_ex_rs2` = 1 in the second cycle.
- With LQ_DEPTH=2: three back-to-back loads to x1, x2, x3 -> the third stalls. `mem_done` arrives while it is stalled -> the third fires the same cycle; `lq_count` stays 2; `ld_head_rd` becomes 2.
- Load x4 outstanding, then `addi x4,x0,9` -> WAW `stall` until `mem_done`; then fires with `pending[4]` = 0.
- Load to x0, then `add x9,x0,x0` -> no stall; `lq_count` = 1; `pending` = 0; `mem_done` returns `lq_count` to 0.
- `mem_done` with an empty queue -> `sb_err` = 1 and stays set. `reset` asserted with 2 loads queued -> `lq_count` = 0, `pending` = 0, `sb_err` = 0 asynchronously.
